// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with hold and optional timed sweep.
// Ports: clk, rst (async high), en, load, din[W], sweep -> dout[2**W], code[W], valid, done.
// Macro DECODER_SEQ_SWEEP_EN compiles in the SWEEP state, dwell counter and done pulse.
module decoder_seq #(
  parameter int WIDTH = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      din,
  input  logic                  sweep,
  output logic [2**WIDTH-1:0]   dout,
  output logic [WIDTH-1:0]      code,
  output logic                  valid,
  output logic                  done
);

  localparam int N = 2**WIDTH;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SWEEP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [N-1:0]     dout_n;
  logic [WIDTH-1:0] code_n;
  logic             valid_n;
  logic             done_n;

`ifdef DECODER_SEQ_SWEEP_EN
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [WIDTH-1:0] LAST_CODE  = {WIDTH{1'b1}};

  logic [7:0] cnt;
  logic [7:0] cnt_n;
`else
  localparam int unused_dwell = DWELL;
  logic unused_sweep;
  assign unused_sweep = sweep;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dout  <= '0;
      code  <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
`ifdef DECODER_SEQ_SWEEP_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      dout  <= dout_n;
      code  <= code_n;
      valid <= valid_n;
      done  <= done_n;
`ifdef DECODER_SEQ_SWEEP_EN
      cnt   <= cnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    dout_n  = dout;
    code_n  = code;
    valid_n = valid;
    done_n  = 1'b0;
`ifdef DECODER_SEQ_SWEEP_EN
    cnt_n   = cnt;
`endif
    if (!en) begin
      state_n = IDLE;
      dout_n  = '0;
      code_n  = '0;
      valid_n = 1'b0;
`ifdef DECODER_SEQ_SWEEP_EN
      cnt_n   = '0;
`endif
    end else if (load) begin
      // load outranks sweep and aborts a running sweep
      state_n = HOLD;
      dout_n  = ONE << din;
      code_n  = din;
      valid_n = 1'b1;
`ifdef DECODER_SEQ_SWEEP_EN
      cnt_n   = '0;
`endif
    end else begin
      unique case (state)
        IDLE, HOLD: begin
`ifdef DECODER_SEQ_SWEEP_EN
          if (sweep) begin
            state_n = SWEEP;
            dout_n  = ONE;
            code_n  = '0;
            valid_n = 1'b1;
            cnt_n   = '0;
          end
`endif
        end
        SWEEP: begin
`ifdef DECODER_SEQ_SWEEP_EN
          // cnt counts cycles already spent on the current code
          if (cnt == DWELL_LAST) begin
            cnt_n = '0;
            if (code == LAST_CODE) begin
              state_n = IDLE;
              dout_n  = '0;
              code_n  = '0;
              valid_n = 1'b0;
              done_n  = 1'b1;
            end else begin
              code_n = code + WIDTH'(1);
              dout_n = dout << 1;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
`else
          state_n = IDLE;
          dout_n  = '0;
          code_n  = '0;
          valid_n = 1'b0;
`endif
        end
        default: begin
          state_n = IDLE;
          dout_n  = '0;
          code_n  = '0;
          valid_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: vector table, corner-case sequences and a random
// run against a cycle-count reference model of decoder_seq.
module tb_decoder_seq;

  localparam int W  = 3;
  localparam int DW = 4;
  localparam int N  = 2**W;
`ifdef DECODER_SEQ_SWEEP_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] din;
  logic         sweep;
  logic [N-1:0] dout;
  logic [W-1:0] code;
  logic         valid;
  logic         done;

  int checks = 0;
  int errors = 0;

  decoder_seq #(.WIDTH(W), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .din(din), .sweep(sweep), .dout(dout),
    .code(code), .valid(valid), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic         load;
    logic [W-1:0] din;
    logic         sweep;
    logic [N-1:0] e_dout;
    logic [W-1:0] e_code;
    logic         e_valid;
    logic         e_done;
  } vec_t;

  vec_t tbl[15];

  // reference model: sweep position is a plain cycle count since start
  bit m_active;
  bit m_sweeping;
  int m_code;
  int m_t;
  bit m_done;

  task automatic chk(string nm, logic [N-1:0] ed, logic [W-1:0] ec,
                     logic ev, logic edn);
    checks++;
    if (dout !== ed || code !== ec || valid !== ev || done !== edn) begin
      errors++;
      $display("FAIL %s got dout=%h code=%0d valid=%b done=%b exp dout=%h code=%0d valid=%b done=%b",
               nm, dout, code, valid, done, ed, ec, ev, edn);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_active = 0; m_sweeping = 0; m_code = 0; m_t = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (!en) begin
      m_active = 0; m_sweeping = 0; m_code = 0;
    end else if (load) begin
      m_active = 1; m_sweeping = 0; m_code = int'(din);
    end else if (m_sweeping) begin
      m_t++;
      if (m_t == N * DW) begin
        m_sweeping = 0; m_active = 0; m_code = 0; m_done = 1;
      end else begin
        m_code = m_t / DW;
      end
    end else if (sweep && SW) begin
      m_sweeping = 1; m_active = 1; m_t = 0; m_code = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] ed;
    logic [W-1:0] ec;
    logic [N-1:0] one;
    one = 1;

    rst = 1'b1; en = 0; load = 0; din = 0; sweep = 0;
    #12;
    chk("reset_state", '0, '0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    tbl[0]  = '{1, 1, 3'd0, 0, 8'h01, 3'd0, 1, 0};
    tbl[1]  = '{1, 1, 3'd1, 0, 8'h02, 3'd1, 1, 0};
    tbl[2]  = '{1, 1, 3'd2, 0, 8'h04, 3'd2, 1, 0};
    tbl[3]  = '{1, 1, 3'd3, 0, 8'h08, 3'd3, 1, 0};
    tbl[4]  = '{1, 1, 3'd4, 0, 8'h10, 3'd4, 1, 0};
    tbl[5]  = '{1, 1, 3'd5, 0, 8'h20, 3'd5, 1, 0};
    tbl[6]  = '{1, 1, 3'd6, 0, 8'h40, 3'd6, 1, 0};
    tbl[7]  = '{1, 1, 3'd7, 0, 8'h80, 3'd7, 1, 0};
    tbl[8]  = '{1, 0, 3'd5, 0, 8'h80, 3'd7, 1, 0};
    tbl[9]  = '{1, 1, 3'd4, 0, 8'h10, 3'd4, 1, 0};
    tbl[10] = '{1, 0, 3'd1, 0, 8'h10, 3'd4, 1, 0};
    tbl[11] = '{0, 0, 3'd1, 0, 8'h00, 3'd0, 0, 0};
    tbl[12] = '{0, 1, 3'd3, 1, 8'h00, 3'd0, 0, 0};
    tbl[13] = '{1, 1, 3'd1, 1, 8'h02, 3'd1, 1, 0};
    tbl[14] = '{0, 0, 3'd0, 0, 8'h00, 3'd0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; load = tbl[i].load;
      din = tbl[i].din; sweep = tbl[i].sweep;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_code,
          tbl[i].e_valid, tbl[i].e_done);
    end

    // full sweep; sweep held high for a while must not restart it
    en = 1; load = 0; sweep = 1;
    for (int i = 0; i < N * DW; i++) begin
      tick();
      if (i == 20) sweep = 0;
      ec = W'(i / DW);
      ed = one << ec;
      if (SW) chk($sformatf("sweep%0d", i), ed, ec, 1, 0);
      else    chk($sformatf("nosweep%0d", i), '0, '0, 0, 0);
    end
    tick();
    chk("sweep_end", '0, '0, 0, SW);
    tick();
    chk("sweep_after", '0, '0, 0, 0);

    // abort at code 3 with load din=6
    sweep = 1;
    tick();
    sweep = 0;
    for (int i = 1; i <= 3 * DW; i++) tick();
    if (SW) chk("abort_pre", 8'h08, 3'd3, 1, 0);
    else    chk("abort_pre", '0, '0, 0, 0);
    load = 1; din = 3'd6;
    tick();
    load = 0;
    chk("abort_load", 8'h40, 3'd6, 1, 0);
    for (int i = 0; i < N * DW + 4; i++) begin
      tick();
      if (done !== 1'b0 || dout !== 8'h40) begin
        chk("abort_hold", 8'h40, 3'd6, 1, 0);
        break;
      end
    end
    chk("abort_hold_end", 8'h40, 3'd6, 1, 0);

    // async reset mid-sweep
    en = 0;
    tick();
    en = 1; sweep = 1;
    tick();
    sweep = 0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1;
    #1;
    chk("rst_async", '0, '0, 0, 0);
    @(negedge clk);
    rst = 0;
    load = 1; din = 3'd2;
    tick();
    load = 0;
    chk("rst_then_load", 8'h04, 3'd2, 1, 0);
    for (int i = 0; i < N * DW + 2; i++) tick();
    chk("rst_no_done", 8'h04, 3'd2, 1, 0);

    // randomized run against model
    en = 0; load = 0; sweep = 0;
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom % 16) != 0;
      load  = ($urandom % 12) == 0;
      sweep = ($urandom % 6) == 0;
      din   = W'($urandom);
      @(posedge clk);
      model_step();
      #1;
      ec = m_active ? W'(m_code) : '0;
      ed = m_active ? (one << ec) : '0;
      chk($sformatf("rand%0d", c), ed, ec, m_active, m_done);
      checks++;
      if (valid ? !$onehot(dout) : (dout != '0)) begin
        errors++;
        $display("FAIL onehot%0d got dout=%h valid=%b", c, dout, valid);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter WIDTH, default 3: select-code width, legal range 1..8.
REQ-002 Parameter DWELL, default 4: cycles each code is held in sweep mode, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  block enable; low forces a return to idle.
REQ-006 load  input  1  capture din and decode it (sampled only when en=1).
REQ-007 din  input  WIDTH  select code to decode.
REQ-008 sweep  input  1  start an automatic walk through all codes (sampled only when en=1).
REQ-009 dout  output  2**WIDTH  registered one-hot decode; all zeros when not valid.
REQ-010 code  output  WIDTH  registered code currently driven on dout.
REQ-011 valid  output  1  high while dout carries a decoded value.
REQ-012 done  output  1  one-cycle pulse when a sweep completes normally.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, HOLD and SWEEP.
REQ-014 In IDLE: dout=0, code=0, valid=0.
REQ-015 IDLE or HOLD, en=1, load=1: the cycle after the edge, dout=1<<din, code=din, valid=1, state HOLD (latency 1).
REQ-016 HOLD, en=1, load=0, sweep=0: dout, code and valid hold unchanged.
REQ-017 IDLE or HOLD, en=1, sweep=1, load=0: next cycle state SWEEP, code=0, dout=1, valid=1, dwell counter cleared.
REQ-018 SWEEP: each code SHALL be held exactly DWELL cycles, then code increments by 1 and dout shifts left by one.
REQ-019 SWEEP, last code (2**WIDTH-1) after DWELL cycles: next cycle state IDLE, dout=0, valid=0, done=1 for exactly one cycle; no wrap to code 0.
REQ-020 load and sweep asserted together: load wins (REQ-015).
REQ-021 load=1 in SWEEP with en=1: sweep aborts, REQ-015 applies, done stays 0.
REQ-022 sweep=1 in SWEEP: ignored; the sweep does not restart.
REQ-023 en=0 in any state: next cycle IDLE, outputs per REQ-014, done=0; load and sweep ignored.
REQ-024 DWELL=1: code advances every cycle; a full sweep occupies exactly 2**WIDTH cycles of valid=1.
REQ-025 dout SHALL be one-hot whenever valid=1 and all zeros whenever valid=0.
REQ-026 dout and code SHALL be driven from flops, with no combinational path from any input.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state IDLE, dout=0, code=0, valid=0, done=0 and the dwell counter to 0.
REQ-028 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; after release the block waits in IDLE for a new command.
REQ-029 The first rising edge after rst falls SHALL sample inputs normally.

Configuration
REQ-030 Macro DECODER_SEQ_SWEEP_EN: when defined, the SWEEP state, dwell counter and done output logic are compiled in as specified.
REQ-031 With DECODER_SEQ_SWEEP_EN undefined: sweep is ignored, SWEEP is unreachable, done is tied 0, and DWELL has no effect; all other behaviour is unchanged.

Verification
REQ-032 WIDTH=3, reset, then load with din=0..7 on successive cycles, en=1 -> each next cycle dout=8'h01,02,04,...,80, code=din, valid=1.
REQ-033 WIDTH=3, DWELL=4, sweep pulse -> dout walks 01..80, each value for 4 cycles (32 cycles total), then dout=0, valid=0, done=1 for one cycle.
REQ-034 Sweep running at code 3, load with din=6 -> next cycle dout=8'h40, code=6, state HOLD, done never pulses.
REQ-035 HOLD with dout=8'h10, drop en -> next cycle dout=0, valid=0; load=1 with en=0 -> no change.
REQ-036 Assert rst mid-sweep between clock edges -> outputs zero immediately; release, load with din=2 -> dout=8'h04.
REQ-037 Build without DECODER_SEQ_SWEEP_EN, pulse sweep -> dout stays 0, valid=0, done=0; load still decodes per REQ-032.
